// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU fetches and MEMU loads/stores, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise MEMU always wins ties.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_req_addr,
  output logic                    if_resp_valid,
  output logic [DATA_WIDTH-1:0]   if_resp_rdata,
  input  logic                    mem_req_valid,
  output logic                    mem_req_ready,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_req_wen,
  input  logic [DATA_WIDTH-1:0]   mem_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_req_wmask,
  output logic                    mem_resp_valid,
  output logic [DATA_WIDTH-1:0]   mem_resp_rdata,
  output logic                    s_req_valid,
  input  logic                    s_req_ready,
  output logic [ADDR_WIDTH-1:0]   s_req_addr,
  output logic                    s_req_wen,
  output logic [DATA_WIDTH-1:0]   s_req_wdata,
  output logic [DATA_WIDTH/8-1:0] s_req_wmask,
  input  logic                    s_resp_valid,
  input  logic [DATA_WIDTH-1:0]   s_resp_rdata,
  output logic [1:0]              dbg_state
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0]   wmask_q, wmask_d;

  logic grant_if;
  logic grant_mem;
  logic mem_wins_tie;
  logic resp_fire;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q = 1 when MEMU received the most recent grant.
  logic rr_q, rr_d;

  assign mem_wins_tie = ~rr_q;

  always_comb begin
    rr_d = rr_q;
    if (grant_mem) begin
      rr_d = 1'b1;
    end else if (grant_if) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign mem_wins_tie = 1'b1;
`endif

  // Handshakes: a request transfers on a cycle where valid && ready; the master
  // holds valid and its fields until then. Responses are single-cycle pulses
  // with no back-pressure, and s_resp_valid is only consumed in ST_RESP.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (rst && (state_q == ST_IDLE)) begin
      if (mem_req_valid && (!if_req_valid || mem_wins_tie)) begin
        grant_mem = 1'b1;
      end else if (if_req_valid) begin
        grant_if = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_mem) begin
          owner_d = 1'b1;
          addr_d  = mem_req_addr;
          wen_d   = mem_req_wen;
          wdata_d = mem_req_wdata;
          wmask_d = mem_req_wmask;
          state_d = ST_REQ;
        end else if (grant_if) begin
          owner_d = 1'b0;
          addr_d  = if_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (s_req_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (s_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  // Gated by rst so nothing leaks out of a transaction being abandoned by reset.
  assign resp_fire = rst && (state_q == ST_RESP) && s_resp_valid;

  assign if_req_ready   = grant_if;
  assign mem_req_ready  = grant_mem;
  assign if_resp_valid  = resp_fire && !owner_q;
  assign if_resp_rdata  = if_resp_valid ? s_resp_rdata : '0;
  assign mem_resp_valid = resp_fire && owner_q;
  assign mem_resp_rdata = (mem_resp_valid && !wen_q) ? s_resp_rdata : '0;

  assign s_req_valid = (state_q == ST_REQ);
  assign s_req_addr  = addr_q;
  assign s_req_wen   = wen_q;
  assign s_req_wdata = wdata_q;
  assign s_req_wmask = wmask_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle transaction model plus directed scenarios
// with hand-computed grant order, response data and latency.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk;
  logic          rst;
  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_resp_valid;
  logic [DW-1:0] if_resp_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_wen;
  logic [DW-1:0] mem_req_wdata;
  logic [MW-1:0] mem_req_wmask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_rdata;
  logic          s_req_valid;
  logic          s_req_ready;
  logic [AW-1:0] s_req_addr;
  logic          s_req_wen;
  logic [DW-1:0] s_req_wdata;
  logic [MW-1:0] s_req_wmask;
  logic          s_resp_valid;
  logic [DW-1:0] s_resp_rdata;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_rdata(s_resp_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int          rdy_wait   = 0;
  int          resp_wait  = 0;
  bit          early_resp = 1'b0;
  logic [31:0] resp_data  = '0;
  int          rdy_cnt    = 0;
  int          resp_cnt   = 0;
  bit          in_resp    = 1'b0;

  initial begin
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b0;
    s_resp_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      s_req_ready  = 1'b0;
      s_resp_valid = 1'b0;
      s_resp_rdata = '0;
      if (in_resp) begin
        if (resp_cnt == 0) begin
          s_resp_valid = 1'b1;
          s_resp_rdata = resp_data;
          in_resp      = 1'b0;
        end else begin
          resp_cnt--;
        end
      end else if (s_req_valid === 1'b1) begin
        if (rdy_cnt >= rdy_wait) begin
          s_req_ready = 1'b1;
          rdy_cnt     = 0;
          in_resp     = 1'b1;
          resp_cnt    = resp_wait;
          if (early_resp) begin
            s_resp_valid = 1'b1;
            s_resp_rdata = 32'hBAD0BAD0;
          end
        end else begin
          rdy_cnt++;
        end
      end
    end
  end

  // ---------------- model, logs, per-cycle compare ----------------
  bit          m_active   = 1'b0;
  bit          m_issued   = 1'b0;
  bit          m_owner    = 1'b0;
  bit          m_last_mem = 1'b0;
  logic [31:0] m_addr     = '0;
  logic        m_wen      = 1'b0;
  logic [31:0] m_wdata    = '0;
  logic [3:0]  m_wmask    = '0;

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  int          got_gnt[$];
  int          exp_gnt[$];
  logic [31:0] hs_addr[$];
  logic        hs_wen[$];
  logic [31:0] hs_wdata[$];
  logic [3:0]  hs_wmask[$];
  int          stall_cnt = 0;
  int          grant_cyc = 0;
  int          resp_cyc  = 0;
  int          hs_cyc    = 0;

  always @(negedge clk) begin : cmp
    bit g_if;
    bit g_mem;
    bit e_sv;
    bit e_ir;
    bit e_mr;
    if (chk_en) begin
      g_if  = 1'b0;
      g_mem = 1'b0;
      if (rst && !m_active) begin
        if (if_req_valid && mem_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
          g_mem = !m_last_mem;
          g_if  = m_last_mem;
`else
          g_mem = 1'b1;
`endif
        end else begin
          g_mem = mem_req_valid;
          g_if  = if_req_valid;
        end
      end
      e_sv = m_active && !m_issued;
      e_ir = rst && m_active && m_issued && !m_owner && s_resp_valid;
      e_mr = rst && m_active && m_issued && m_owner && s_resp_valid;

      chk("if_req_ready", if_req_ready, g_if);
      chk("mem_req_ready", mem_req_ready, g_mem);
      chk("s_req_valid", s_req_valid, e_sv);
      if (e_sv) begin
        chk("s_req_addr", s_req_addr, m_addr);
        chk("s_req_wen", s_req_wen, m_wen);
        chk("s_req_wmask", s_req_wmask, m_wmask);
        if (m_wen) chk("s_req_wdata", s_req_wdata, m_wdata);
      end
      chk("if_resp_valid", if_resp_valid, e_ir);
      chk("mem_resp_valid", mem_resp_valid, e_mr);
      if (e_ir) chk("if_resp_rdata", if_resp_rdata, s_resp_rdata);
      if (e_mr) chk("mem_resp_rdata", mem_resp_rdata, m_wen ? 32'h0 : s_resp_rdata);

      if (if_req_ready === 1'b1)  begin got_gnt.push_back(0); grant_cyc = cyc; end
      if (mem_req_ready === 1'b1) begin got_gnt.push_back(1); grant_cyc = cyc; end
      if (if_resp_valid === 1'b1)  begin got_q.push_back({1'b0, if_resp_rdata}); resp_cyc = cyc; end
      if (mem_resp_valid === 1'b1) begin got_q.push_back({1'b1, mem_resp_rdata}); resp_cyc = cyc; end
      if (s_req_valid === 1'b1 && s_req_ready) begin
        hs_addr.push_back(s_req_addr);
        hs_wen.push_back(s_req_wen);
        hs_wdata.push_back(s_req_wdata);
        hs_wmask.push_back(s_req_wmask);
        hs_cyc = cyc;
      end
      if (s_req_valid === 1'b1 && !s_req_ready) stall_cnt++;

      // advance the model to what the coming clock edge does
      if (!rst) begin
        m_active   = 1'b0;
        m_issued   = 1'b0;
        m_last_mem = 1'b0;
      end else if (!m_active) begin
        if (g_if || g_mem) begin
          m_active   = 1'b1;
          m_issued   = 1'b0;
          m_owner    = g_mem;
          m_last_mem = g_mem;
          m_addr     = g_mem ? mem_req_addr  : if_req_addr;
          m_wen      = g_mem ? mem_req_wen   : 1'b0;
          m_wdata    = g_mem ? mem_req_wdata : 32'h0;
          m_wmask    = g_mem ? mem_req_wmask : 4'h0;
        end
      end else if (!m_issued) begin
        if (s_req_ready) m_issued = 1'b1;
      end else if (s_resp_valid) begin
        m_active = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive_reqs(input bit iv, input logic [31:0] ia, input bit mv,
                            input logic [31:0] ma, input bit w,
                            input logic [31:0] wd, input logic [3:0] wm);
    bit ip;
    bit mp;
    int budget;
    @(posedge clk);
    #1;
    if_req_valid  = iv;
    if_req_addr   = ia;
    mem_req_valid = mv;
    mem_req_addr  = ma;
    mem_req_wen   = w;
    mem_req_wdata = wd;
    mem_req_wmask = wm;
    ip = iv;
    mp = mv;
    budget = 0;
    while ((ip || mp) && budget < 200) begin
      @(negedge clk);
      if (ip && if_req_ready === 1'b1) ip = 1'b0;
      if (mp && mem_req_ready === 1'b1) mp = 1'b0;
      @(posedge clk);
      #1;
      if (!ip) if_req_valid = 1'b0;
      if (!mp) mem_req_valid = 1'b0;
      budget++;
    end
    chk("req_accept_timeout", {62'd0, ip, mp}, 64'd0);
    if_req_valid  = 1'b0;
    mem_req_valid = 1'b0;
  endtask

  task automatic tie_run(input int n, input logic [31:0] ia, input logic [31:0] ma);
    int target;
    int budget;
    target = got_gnt.size() + n;
    budget = 0;
    @(posedge clk);
    #1;
    if_req_valid  = 1'b1;
    if_req_addr   = ia;
    mem_req_valid = 1'b1;
    mem_req_addr  = ma;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    mem_req_wmask = 4'hF;
    while (got_gnt.size() < target && budget < 300) begin
      @(negedge clk);
      #1;
      budget++;
    end
    chk("tie_grant_count", got_gnt.size(), target);
    @(posedge clk);
    #1;
    if_req_valid  = 1'b0;
    mem_req_valid = 1'b0;
  endtask

  task automatic wait_resps();
    int budget;
    budget = 0;
    while (got_q.size() < exp_q.size() && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    chk("resp_count", got_q.size(), exp_q.size());
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_resps(input string tag);
    logic [32:0] e;
    logic [32:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 33'h1_FFFF_FFFF;
      chk({tag, "_resp"}, g, e);
    end
    chk({tag, "_extra_resp"}, got_q.size(), 0);
    got_q.delete();
  endtask

  task automatic check_gnts(input string tag);
    int e;
    int g;
    while (exp_gnt.size() > 0) begin
      e = exp_gnt.pop_front();
      g = (got_gnt.size() > 0) ? got_gnt.pop_front() : -1;
      chk({tag, "_grant_owner"}, g, e);
    end
    chk({tag, "_extra_grant"}, got_gnt.size(), 0);
    got_gnt.delete();
  endtask

  task automatic check_hs(input string tag, input logic [31:0] a, input logic w,
                          input logic [31:0] wd, input logic [3:0] wm);
    if (hs_addr.size() == 0) begin
      chk({tag, "_hs_present"}, 0, 1);
    end else begin
      chk({tag, "_hs_addr"}, hs_addr.pop_front(), a);
      chk({tag, "_hs_wen"}, hs_wen.pop_front(), w);
      chk({tag, "_hs_wmask"}, hs_wmask.pop_front(), wm);
      if (w) chk({tag, "_hs_wdata"}, hs_wdata.pop_front(), wd);
      else void'(hs_wdata.pop_front());
    end
  endtask

  task automatic clear_hs();
    hs_addr.delete();
    hs_wen.delete();
    hs_wdata.delete();
    hs_wmask.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    rst           = 1'b0;
    if_req_valid  = 1'b0;
    if_req_addr   = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;

    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_s_req_valid", s_req_valid, 0);
    chk("rst_s_req_addr", s_req_addr, 0);
    chk("rst_s_req_wen", s_req_wen, 0);
    chk("rst_s_req_wdata", s_req_wdata, 0);
    chk("rst_s_req_wmask", s_req_wmask, 0);
    chk("rst_if_resp_valid", if_resp_valid, 0);
    chk("rst_mem_resp_valid", mem_resp_valid, 0);
    chk("rst_if_resp_rdata", if_resp_rdata, 0);
    chk("rst_mem_resp_rdata", mem_resp_rdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: lone IFU fetch at minimum latency
    clear_hs();
    rdy_wait = 0; resp_wait = 0; resp_data = 32'h00000413;
    exp_q.push_back({1'b0, 32'h00000413});
    exp_gnt.push_back(0);
    drive_reqs(1'b1, 32'h80000000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    wait_resps();
    settle(3);
    check_resps("t1");
    check_gnts("t1");
    check_hs("t1", 32'h80000000, 1'b0, 32'h0, 4'h0);
    chk("t1_latency", resp_cyc - grant_cyc, 2);

    // 2: tie, MEMU store served before IFU fetch
    clear_hs();
    rdy_wait = 0; resp_wait = 1; resp_data = 32'h12345678;
    exp_gnt.push_back(1);
    exp_gnt.push_back(0);
    exp_q.push_back({1'b1, 32'h00000000});
    exp_q.push_back({1'b0, 32'h12345678});
    drive_reqs(1'b1, 32'h80000004, 1'b1, 32'h80001000, 1'b1, 32'hDEADBEEF, 4'hF);
    wait_resps();
    settle(3);
    check_resps("t2");
    check_gnts("t2");
    check_hs("t2_store", 32'h80001000, 1'b1, 32'hDEADBEEF, 4'hF);
    check_hs("t2_fetch", 32'h80000004, 1'b0, 32'h0, 4'h0);

    // 3: memory stalls s_req_ready for 5 cycles on each of two transactions
    clear_hs();
    stall_cnt = 0;
    rdy_wait = 5; resp_wait = 0; resp_data = 32'hCAFEF00D;
    exp_gnt.push_back(1);
    exp_gnt.push_back(0);
    exp_q.push_back({1'b1, 32'hCAFEF00D});
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    drive_reqs(1'b1, 32'h80000008, 1'b1, 32'h80002000, 1'b0, 32'h0, 4'hF);
    wait_resps();
    settle(3);
    check_resps("t3");
    check_gnts("t3");
    chk("t3_stall_cycles", stall_cnt, 10);

    // 6: response coincident with the request handshake is ignored
    clear_hs();
    rdy_wait = 1; resp_wait = 2; early_resp = 1'b1; resp_data = 32'h600D600D;
    exp_gnt.push_back(0);
    exp_q.push_back({1'b0, 32'h600D600D});
    drive_reqs(1'b1, 32'h80000010, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    wait_resps();
    settle(4);
    early_resp = 1'b0;
    check_resps("t6");
    check_gnts("t6");
    chk("t6_hs_to_resp", resp_cyc - hs_cyc, 3);

    // 4: reset while waiting for a store response; late response must be dropped
    clear_hs();
    rdy_wait = 0; resp_wait = 4; resp_data = 32'h44444444;
    exp_gnt.push_back(1);
    drive_reqs(1'b0, 32'h0, 1'b1, 32'h80004000, 1'b1, 32'hA5A5A5A5, 4'h5);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t4_post_rst_s_req_valid", s_req_valid, 0);
    chk("t4_post_rst_s_req_addr", s_req_addr, 0);
    chk("t4_post_rst_s_req_wen", s_req_wen, 0);
    chk("t4_post_rst_s_req_wdata", s_req_wdata, 0);
    chk("t4_post_rst_s_req_wmask", s_req_wmask, 0);
    settle(8);
    chk("t4_no_resp_after_rst", got_q.size(), 0);
    resp_wait = 0; resp_data = 32'h55555555;
    exp_gnt.push_back(0);
    exp_q.push_back({1'b0, 32'h55555555});
    drive_reqs(1'b1, 32'h80000030, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    wait_resps();
    settle(3);
    check_resps("t4");
    check_gnts("t4");

    // 5: four back-to-back ties
    rdy_wait = 0; resp_wait = 0; resp_data = 32'h77777777;
`ifdef ARB_ROUND_ROBIN_EN
    exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0);
    exp_q.push_back({1'b1, 32'h77777777}); exp_q.push_back({1'b0, 32'h77777777});
    exp_q.push_back({1'b1, 32'h77777777}); exp_q.push_back({1'b0, 32'h77777777});
`else
    exp_gnt.push_back(1); exp_gnt.push_back(1); exp_gnt.push_back(1); exp_gnt.push_back(1);
    exp_q.push_back({1'b1, 32'h77777777}); exp_q.push_back({1'b1, 32'h77777777});
    exp_q.push_back({1'b1, 32'h77777777}); exp_q.push_back({1'b1, 32'h77777777});
`endif
    tie_run(4, 32'h80000040, 32'h80005000);
    wait_resps();
    settle(3);
    check_resps("t5");
    check_gnts("t5");

    settle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
